// File: rtl/baud_pkg.sv
// baud_pkg: shared widths, config bundle and clamp helper
// for the runtime-programmable fractional-N baud generator.
package baud_pkg;

   localparam int DIV_W = 16;
   localparam int ACC_W = 24;
   localparam int OSR_W = 5;

   localparam logic [DIV_W-1:0] MIN_DIV = DIV_W'(2);
   localparam logic [OSR_W-1:0] MIN_OSR = OSR_W'(2);

   typedef struct packed {
      logic [DIV_W-1:0] div_n;
      logic [ACC_W-1:0] frac;
      logic [OSR_W-1:0] osr;
   } baud_cfg_t;

   // Divisor and OSR below 2 cannot produce distinct strobes,
   // so they are raised to the minimum before use.
   function automatic baud_cfg_t clamp_cfg(input baud_cfg_t c);
      baud_cfg_t r;
      r = c;
      if (c.div_n < MIN_DIV) r.div_n = MIN_DIV;
      if (c.osr < MIN_OSR) r.osr = MIN_OSR;
      return r;
   endfunction

endpackage

// File: rtl/baud_frac_div.sv
// baud_frac_div: fractional-N divider producing the oversample
// strobe. Ports: clk, rst_n, en, sync, clr_acc (clear accumulator
// on this strobe), div_n, frac, fire (comb: strobe on next edge),
// tick_osr (registered 1-clk strobe).
module baud_frac_div
   import baud_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             sync,
   input  logic             clr_acc,
   input  logic [DIV_W-1:0] div_n,
   input  logic [ACC_W-1:0] frac,
   output logic             fire,
   output logic             tick_osr
);

   logic [DIV_W-1:0] div_cnt;
   logic [ACC_W-1:0] acc;
   logic             carry;
   logic             last;
   logic [DIV_W:0]   cnt_p1;
   logic [DIV_W:0]   period;
   logic [ACC_W:0]   acc_sum;

   // Period is div_n plus the carry left by the previous strobe.
   always_comb begin
      cnt_p1  = {1'b0, div_cnt} + (DIV_W+1)'(1);
      period  = {1'b0, div_n} + {{DIV_W{1'b0}}, carry};
      last    = (cnt_p1 == period);
      fire    = en & ~sync & last;
      acc_sum = {1'b0, acc} + {1'b0, frac};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt  <= '0;
         acc      <= '0;
         carry    <= 1'b0;
         tick_osr <= 1'b0;
      end else begin
         tick_osr <= fire;
         if (!en || sync) begin
            div_cnt <= '0;
            acc     <= '0;
            carry   <= 1'b0;
         end else if (last) begin
            div_cnt <= '0;
            if (clr_acc) begin
               acc   <= '0;
               carry <= 1'b0;
            end else begin
               acc   <= acc_sum[ACC_W-1:0];
               carry <= acc_sum[ACC_W];
            end
         end else begin
            div_cnt <= div_cnt + DIV_W'(1);
         end
      end
   end

endmodule

// File: rtl/baud_gen_frac_prog.sv
// baud_gen_frac_prog: programmable fractional-N baud tick generator.
// Ports: clk, rst_n, en, sync, cfg_valid/cfg_ready/cfg_int/cfg_frac/
// cfg_osr (config handshake), tick_osr, tick_bit (1-clk strobes).
// Widths DIV_W/ACC_W/OSR_W come from baud_pkg.
module baud_gen_frac_prog
   import baud_pkg::*;
#(
   parameter logic [DIV_W-1:0] RST_N    = DIV_W'(27),
   parameter logic [ACC_W-1:0] RST_FRAC = ACC_W'(2144484),
   parameter logic [OSR_W-1:0] RST_OSR  = OSR_W'(16)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             sync,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [DIV_W-1:0] cfg_int,
   input  logic [ACC_W-1:0] cfg_frac,
   input  logic [OSR_W-1:0] cfg_osr,
   output logic             tick_osr,
   output logic             tick_bit
);

   localparam baud_cfg_t RST_CFG = clamp_cfg('{
      div_n: RST_N, frac: RST_FRAC, osr: RST_OSR});

   baud_cfg_t        act_q;
   baud_cfg_t        pend_q;
   baud_cfg_t        cfg_in;
   logic             pend_vld;
   logic [OSR_W-1:0] osr_cnt;
   logic             fire;
   logic             osr_last;
   logic             bit_fire;
   logic             load;
   logic             apply;

   assign cfg_ready = ~pend_vld;

   // Pending config swaps in only where the phase restarts:
   // a bit boundary, a sync pulse, or while idle.
   always_comb begin
      cfg_in   = clamp_cfg('{
         div_n: cfg_int, frac: cfg_frac, osr: cfg_osr});
      load     = cfg_valid & ~pend_vld;
      osr_last = (osr_cnt + OSR_W'(1)) == act_q.osr;
      bit_fire = fire & osr_last;
      apply    = pend_vld & (~en | sync | bit_fire);
   end

   baud_frac_div u_div (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .sync     (sync),
      .clr_acc  (apply),
      .div_n    (act_q.div_n),
      .frac     (act_q.frac),
      .fire     (fire),
      .tick_osr (tick_osr)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         act_q    <= RST_CFG;
         pend_q   <= RST_CFG;
         pend_vld <= 1'b0;
         osr_cnt  <= '0;
         tick_bit <= 1'b0;
      end else begin
         tick_bit <= bit_fire;
         if (!en || sync) begin
            osr_cnt <= '0;
         end else if (fire) begin
            osr_cnt <= bit_fire ? '0 : osr_cnt + OSR_W'(1);
         end
         if (apply) act_q <= pend_q;
         if (load) pend_q <= cfg_in;
         if (load) begin
            pend_vld <= 1'b1;
         end else if (apply) begin
            pend_vld <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_baud_gen_frac_prog.sv
// tb_baud_gen_frac_prog: directed vectors and corner sequences
// for the fractional-N baud generator.
module tb_baud_gen_frac_prog;
   import baud_pkg::*;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             en;
   logic             sync;
   logic             cfg_valid;
   logic             cfg_ready;
   logic [DIV_W-1:0] cfg_int;
   logic [ACC_W-1:0] cfg_frac;
   logic [OSR_W-1:0] cfg_osr;
   logic             tick_osr;
   logic             tick_bit;

   always #5 clk = ~clk;

   baud_gen_frac_prog dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .sync      (sync),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .cfg_int   (cfg_int),
      .cfg_frac  (cfg_frac),
      .cfg_osr   (cfg_osr),
      .tick_osr  (tick_osr),
      .tick_bit  (tick_bit)
   );

   typedef struct packed {
      logic [15:0]      n;
      logic [23:0]      frac;
      logic [4:0]       osr;
      logic [5:0]       osr_eff;
      logic [0:5][3:0]  gap;
   } vec_t;

   vec_t vecs [5];

   int   n_chk = 0;
   int   n_fail = 0;
   int   since = 0;
   int   gap = 0;
   int   stray = 0;
   logic prev_tick = 1'b0;

   task automatic check(input string name, input int got,
                        input int exp);
      n_chk++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      since++;
      if (tick_bit && !tick_osr) stray++;
      if (tick_osr && prev_tick) stray++;
      prev_tick = tick_osr;
      if (tick_osr) begin
         gap = since;
         since = 0;
      end
   endtask

   task automatic wait_tick(input int budget);
      int k;
      k = 0;
      do begin
         step();
         k++;
      end while (!tick_osr && k < budget);
      if (!tick_osr) check("tick_timeout", 0, 1);
   endtask

   task automatic load_cfg(input int n, input int f, input int o);
      int k;
      k = 0;
      while (!cfg_ready && k < 5000) begin
         step();
         k++;
      end
      if (!cfg_ready) check("ready_timeout", 0, 1);
      cfg_valid = 1'b1;
      cfg_int   = DIV_W'(n);
      cfg_frac  = ACC_W'(f);
      cfg_osr   = OSR_W'(o);
      step();
      cfg_valid = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      en = 1'b0;
      sync = 1'b0;
      cfg_valid = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      step();
   endtask

   task automatic wait_bit(input int max_ticks);
      int k;
      k = 0;
      do begin
         wait_tick(200);
         k++;
      end while (!tick_bit && k < max_ticks);
      if (!tick_bit) check("bit_timeout", 0, 1);
   endtask

   initial begin
      int n28, bad, bitbad, tot, nt, rdy_bad, cnt;
      logic hit;

      vecs[0] = '{n: 16'd4, frac: 24'h800000, osr: 5'd4,
                  osr_eff: 6'd4,
                  gap: {4'd4, 4'd4, 4'd5, 4'd4, 4'd5, 4'd4}};
      vecs[1] = '{n: 16'd1, frac: 24'h0, osr: 5'd0,
                  osr_eff: 6'd2,
                  gap: {4'd2, 4'd2, 4'd2, 4'd2, 4'd2, 4'd2}};
      vecs[2] = '{n: 16'd3, frac: 24'h400000, osr: 5'd3,
                  osr_eff: 6'd3,
                  gap: {4'd3, 4'd3, 4'd3, 4'd3, 4'd4, 4'd3}};
      vecs[3] = '{n: 16'd0, frac: 24'hFFFFFF, osr: 5'd1,
                  osr_eff: 6'd2,
                  gap: {4'd2, 4'd2, 4'd3, 4'd3, 4'd3, 4'd3}};
      vecs[4] = '{n: 16'd5, frac: 24'h0, osr: 5'd31,
                  osr_eff: 6'd31,
                  gap: {4'd5, 4'd5, 4'd5, 4'd5, 4'd5, 4'd5}};

      cfg_int = '0;
      cfg_frac = '0;
      cfg_osr = '0;
      do_reset();
      check("rst_tick_osr", int'(tick_osr), 0);
      check("rst_tick_bit", int'(tick_bit), 0);
      check("rst_ready", int'(cfg_ready), 1);

      // Reset defaults over 2000 intervals
      en = 1'b1;
      since = 0;
      n28 = 0;
      bad = 0;
      bitbad = 0;
      for (int i = 1; i <= 2000; i++) begin
         wait_tick(100);
         if (i == 1) check("dflt_first", gap, 27);
         if (gap == 28) n28++;
         else if (gap != 27) bad++;
         if (tick_bit != ((i % 16) == 0)) bitbad++;
      end
      check("dflt_spacing", bad, 0);
      check("dflt_n28_ok", int'(n28 == 255 || n28 == 256), 1);
      check("dflt_bit", bitbad, 0);

      // Table-driven configs, loaded while idle
      for (int v = 0; v < 5; v++) begin
         en = 1'b0;
         step();
         load_cfg(int'(vecs[v].n), int'(vecs[v].frac),
                  int'(vecs[v].osr));
         check($sformatf("v%0d_pend", v), int'(cfg_ready), 0);
         step();
         check($sformatf("v%0d_idle_apply", v), int'(cfg_ready), 1);
         en = 1'b1;
         since = 0;
         bitbad = 0;
         tot = 2 * int'(vecs[v].osr_eff);
         if (tot < 6) tot = 6;
         for (int i = 1; i <= tot; i++) begin
            wait_tick(200);
            if (i <= 6)
               check($sformatf("v%0d_gap%0d", v, i), gap,
                     int'(vecs[v].gap[i-1]));
            if (tick_bit != ((i % int'(vecs[v].osr_eff)) == 0))
               bitbad++;
         end
         check($sformatf("v%0d_bit", v), bitbad, 0);
      end

      // Config accepted mid-bit is held to the boundary
      do_reset();
      en = 1'b1;
      since = 0;
      wait_bit(20);
      for (int i = 0; i < 5; i++) wait_tick(100);
      cfg_valid = 1'b1;
      cfg_int = DIV_W'(10);
      cfg_frac = '0;
      cfg_osr = OSR_W'(16);
      step();
      cfg_int = DIV_W'(7);
      check("mid_ready_low", int'(cfg_ready), 0);
      nt = 0;
      bad = 0;
      rdy_bad = 0;
      cnt = 0;
      hit = 1'b0;
      while (!hit && cnt < 1000) begin
         step();
         cnt++;
         if (tick_osr) begin
            nt++;
            if (gap != 27 && gap != 28) bad++;
            if (nt == 8) cfg_valid = 1'b0;
         end
         if (tick_bit) hit = 1'b1;
         else if (cfg_ready) rdy_bad++;
      end
      cfg_valid = 1'b0;
      check("mid_boundary_seen", int'(hit), 1);
      check("mid_ticks_to_bit", nt, 11);
      check("mid_old_spacing", bad, 0);
      check("mid_ready_held", rdy_bad, 0);
      check("mid_ready_rise", int'(cfg_ready), 1);
      for (int i = 1; i <= 4; i++) begin
         wait_tick(100);
         check($sformatf("mid_new_gap%0d", i), gap, 10);
      end

      // Sync coincident with a tick edge
      en = 1'b0;
      step();
      load_cfg(6, 0, 4);
      step();
      en = 1'b1;
      since = 0;
      wait_bit(10);
      wait_tick(100);
      for (int i = 0; i < 5; i++) step();
      sync = 1'b1;
      step();
      sync = 1'b0;
      check("sync_no_tick", int'(tick_osr), 0);
      since = 0;
      wait_tick(100);
      check("sync_gap", gap, 6);
      nt = 1;
      while (!tick_bit && nt < 10) begin
         wait_tick(100);
         nt++;
      end
      check("sync_osr_restart", nt, 4);

      // Async reset mid-bit, then en toggling
      do_reset();
      en = 1'b1;
      since = 0;
      wait_bit(20);
      load_cfg(5, 0, 16);
      check("rst_pend_low", int'(cfg_ready), 0);
      for (int i = 0; i < 3; i++) wait_tick(100);
      rst_n = 1'b0;
      en = 1'b0;
      #1;
      check("async_tick_osr", int'(tick_osr), 0);
      check("async_ready", int'(cfg_ready), 1);
      for (int i = 0; i < 3; i++) step();
      rst_n = 1'b1;
      cnt = 0;
      for (int i = 0; i < 5; i++) begin
         step();
         cnt += int'(tick_osr | tick_bit);
      end
      check("idle_no_ticks", cnt, 0);
      en = 1'b1;
      since = 0;
      wait_tick(100);
      check("en_first_gap", gap, 27);
      for (int i = 0; i < 10; i++) step();
      en = 1'b0;
      cnt = 0;
      for (int i = 0; i < 30; i++) begin
         step();
         cnt += int'(tick_osr | tick_bit);
      end
      check("abort_no_ticks", cnt, 0);
      en = 1'b1;
      since = 0;
      wait_tick(100);
      check("reen_first_gap", gap, 27);

      check("stray_strobes", stray, 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
